// File: rtl/counter_updown_k.sv
// Parametrised modulo-K up/down counter with clear, range-checked load, cascade carry and sticky wrap flag.
// Optional saturating mode: define COUNTER_UPDOWN_K_SAT_EN to hold at the limits instead of wrapping.
module counter_updown_k #(
    parameter int WIDTH = 8,
    parameter int K     = 20,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] val,
    output logic             tc,
    output logic             carry_out,
    output logic             wrapped,
    output logic             load_err
);

    // K may equal 2**WIDTH, so the load range check is done one bit wider.
    localparam logic [WIDTH-1:0] K_MAX  = WIDTH'(K - 1);
    localparam logic [WIDTH:0]   K_EXT  = (WIDTH + 1)'(K);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    generate
        if (K < 2 || longint'(K) > (longint'(1) << WIDTH)) begin : g_bad_k
            $error("counter_updown_k: K must satisfy 2 <= K <= 2**WIDTH");
        end
        if (INIT < 0 || INIT >= K) begin : g_bad_init
            $error("counter_updown_k: INIT must satisfy 0 <= INIT < K");
        end
    endgenerate

    logic [WIDTH-1:0] val_q, val_d;
    logic             wrapped_q, wrapped_d;
    logic             load_err_q, load_err_d;
    logic             load_oor;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (val_q == K_MAX);
    assign at_bottom = (val_q == '0);
    assign load_oor  = ({1'b0, load_val} >= K_EXT);

    assign tc        = up ? at_top : at_bottom;
    assign carry_out = en & tc;

    // Priority clr > load > en; the wrap is taken by explicit compare, never by overflow.
    always_comb begin
        val_d      = val_q;
        wrapped_d  = wrapped_q;
        load_err_d = 1'b0;
        if (clr) begin
            val_d     = '0;
            wrapped_d = 1'b0;
        end else if (load) begin
            if (load_oor) begin
                val_d      = K_MAX;
                load_err_d = 1'b1;
            end else begin
                val_d = load_val;
            end
        end else if (en) begin
            if (tc) begin
                wrapped_d = 1'b1;
`ifdef COUNTER_UPDOWN_K_SAT_EN
                val_d = val_q;
`else
                val_d = up ? '0 : K_MAX;
`endif
            end else begin
                val_d = up ? (val_q + WIDTH'(1)) : (val_q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q      <= INIT_V;
            wrapped_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            val_q      <= val_d;
            wrapped_q  <= wrapped_d;
            load_err_q <= load_err_d;
        end
    end

    assign val      = val_q;
    assign wrapped  = wrapped_q;
    assign load_err = load_err_q;

endmodule
